// File: rtl/score_bcd_conv.sv
// score_bcd_conv: iterative double-dabble converter from binary score to packed BCD with leading-zero blanking.
// Ports: clk/rst (async, active-high); start+bin_in request a conversion while idle;
// busy is high during the BIN_W shift cycles; done pulses for one cycle when bcd_out/digit_en update.
module score_bcd_conv #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en
);
  localparam int SW = 4 * DIGITS;
  // 10^DIGITS > 2^BIN_W - 1  <=>  DIGITS > BIN_W*log10(2); log10(2) ~= 0.30103
  if (DIGITS * 100000 <= BIN_W * 30103) begin : g_bad_digits
    $error("score_bcd_conv: DIGITS too small for BIN_W");
  end
  if ((1 << CNT_W) <= BIN_W) begin : g_bad_cnt
    $error("score_bcd_conv: CNT_W too small for BIN_W");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [SW-1:0]     scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  // A digit is shown if it or any more significant digit is nonzero; units always shown.
  function automatic logic [DIGITS-1:0] en_of(input logic [SW-1:0] v);
    logic hi;
    hi = 1'b0;
    en_of = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi = hi | (v[4*k+:4] != 4'd0);
      en_of[k] = hi;
    end
    en_of[0] = 1'b1;
  endfunction
  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = (scr_q[4*k+:4] >= 4'd5) ? scr_q[4*k+:4] + 4'd3 : scr_q[4*k+:4];
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    en_d    = en_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        shift_d = bin_in;
        scr_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else begin
      {scr_d, shift_d} = {adj, shift_q} << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(BIN_W - 1)) begin
        bcd_d   = scr_d;
        en_d    = en_of(scr_d);
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      en_q    <= DIGITS'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign digit_en = en_q;
endmodule

// File: tb/tb_score_bcd_conv.sv
// tb_score_bcd_conv: directed bench with a transaction-level reference model checked every cycle.
module tb_score_bcd_conv;
  localparam int BIN_W = 32;
  localparam int DIGITS = 10;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [BIN_W-1:0] bin_in = '0;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0] digit_en;
  int checks = 0, errors = 0;

  score_bcd_conv dut (.clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy),
                      .done(done), .bcd_out(bcd_out), .digit_en(digit_en));

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  function automatic logic [DIGITS-1:0] en_for(input longint v);
    int n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    en_for = DIGITS'((64'd1 << n) - 1);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request runs for BIN_W cycles, then the result of plain decimal conversion appears.
  logic m_busy, m_done;
  logic [4*DIGITS-1:0] m_bcd;
  logic [DIGITS-1:0] m_en;
  longint m_val;
  int m_rem;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_bcd = '0; m_en = 1; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
          m_bcd = to_bcd(m_val); m_en = en_for(m_val);
        end
      end else if (start) begin
        m_busy = 1; m_val = longint'(bin_in); m_rem = BIN_W;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", longint'(busy), longint'(m_busy));
    chk("done", longint'(done), longint'(m_done));
    chk("bcd_out", longint'(bcd_out), longint'(m_bcd));
    chk("digit_en", longint'(digit_en), longint'(m_en));
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic convert(input logic [BIN_W-1:0] v, input logic [4*DIGITS-1:0] eb, input logic [DIGITS-1:0] ee);
    int n;
    start = 1; bin_in = v;
    @(posedge clk); #1;
    start = 0;
    wait_done(n);
    chk("latency", n, 32);
    chk("lit_bcd", longint'(bcd_out), longint'(eb));
    chk("lit_en", longint'(digit_en), longint'(ee));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_bcd", longint'(bcd_out), 0);
    chk("rst_en", longint'(digit_en), 1);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_en", longint'(digit_en), 1);
    convert(32'd0, 40'h0, 10'h001);
    convert(32'd1234, 40'h0000001234, 10'h00F);
    convert(32'hFFFF_FFFF, 40'h4294967295, 10'h3FF);
    // second request while busy must be ignored
    start = 1; bin_in = 32'd500;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1 start = 1; bin_in = 32'd999;
    @(posedge clk); #1;
    start = 0;
    wait_done(n);
    chk("busy_ign_lat", n, 27);
    chk("busy_ign_bcd", longint'(bcd_out), 40'h0000000500);
    chk("busy_ign_en", longint'(digit_en), 10'h007);
    repeat (40) @(posedge clk);
    #1 chk("no_second_done", longint'(bcd_out), 40'h0000000500);
    // asynchronous reset in the middle of a conversion
    start = 1; bin_in = 32'd77;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_busy", longint'(busy), 0);
    chk("arst_bcd", longint'(bcd_out), 0);
    chk("arst_en", longint'(digit_en), 1);
    @(posedge clk); #1 rst = 0;
    wait_done(n);
    chk("arst_no_done", n, 40);
    convert(32'd77, 40'h0000000077, 10'h003);
    // request presented in the done cycle is accepted
    start = 1; bin_in = 32'd10;
    @(posedge clk); #1;
    start = 0;
    chk("dc_busy0", longint'(busy), 1);
    wait_done(n);
    chk("dc_first", longint'(bcd_out), 40'h0000000010);
    start = 1; bin_in = 32'd10;
    @(posedge clk); #1;
    start = 0;
    chk("dc_busy", longint'(busy), 1);
    chk("dc_done", longint'(done), 0);
    wait_done(n);
    chk("dc_lat", n, 32);
    chk("dc_bcd", longint'(bcd_out), 40'h0000000010);
    chk("dc_en", longint'(digit_en), 10'h003);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
